// File: rtl/find_k_peaks.sv
// find_k_peaks: ranked multi-peak finder for one frame of magnitude bins.
//
// A frame of N_BINS magnitudes is captured on start_i. The design then runs up
// to K_PEAKS passes through an L-level registered max tree. Each pass reports
// the strongest unmasked bin above the captured threshold and masks that bin.
// The frame ends early as soon as a pass finds no qualifying bin.
//
// Ports:
//   clk_i, reset_ni   clock and asynchronous active-low reset
//   start_i           frame request, ignored while busy_o is high
//   data_in_i         flattened magnitudes, bin i at [i*MAG_W +: MAG_W]
//   threshold_i       exclusive minimum magnitude, sampled with start_i
//   peak_valid_o      one-cycle pulse per reported peak
//   peak_mag_o        magnitude of the reported peak (held between pulses)
//   peak_idx_o        bin index of the reported peak (held between pulses)
//   peak_rank_o       0-based rank, strongest first (held between pulses)
//   busy_o            frame in progress
//   done_o            one-cycle pulse ending the frame
//   peak_count_o      peaks reported this frame, valid with done_o
//
// Build option: define FIND_PEAKS_NEIGHBOR_SUPPRESS_EN to also mask the two
// bins adjacent to each reported peak (clipped at both ends, no wrap-around).
module find_k_peaks #(
  parameter int unsigned N_BINS  = 512,
  parameter int unsigned MAG_W   = 16,
  parameter int unsigned K_PEAKS = 4,
  localparam int unsigned L      = $clog2(N_BINS),
  localparam int unsigned RW     = (K_PEAKS > 1) ? $clog2(K_PEAKS) : 1,
  localparam int unsigned CW     = $clog2(K_PEAKS + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    start_i,
  input  logic [N_BINS*MAG_W-1:0] data_in_i,
  input  logic [MAG_W-1:0]        threshold_i,
  output logic                    peak_valid_o,
  output logic [MAG_W-1:0]        peak_mag_o,
  output logic [L-1:0]            peak_idx_o,
  output logic [RW-1:0]           peak_rank_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CW-1:0]           peak_count_o
);

  localparam int unsigned NN = N_BINS - 1;  // internal tree nodes, node 0 is the root

  typedef struct packed {
    logic             v;
    logic [MAG_W-1:0] mag;
    logic [L-1:0]     idx;
  } node_t;

  typedef enum logic [1:0] {StIdle, StSearch, StEmit} state_e;

  // Left child always covers lower bin indices, so keeping it on a tie
  // gives the lower-index winner.
  function automatic node_t pick(input node_t a, input node_t b);
    if (b.v && (!a.v || (b.mag > a.mag))) begin
      return b;
    end
    return a;
  endfunction

  state_e                  state_q, state_d;
  logic [L-1:0]            wait_q, wait_d;
  logic [N_BINS-1:0]       mask_q, mask_d;
  logic [N_BINS*MAG_W-1:0] frame_q, frame_d;
  logic [MAG_W-1:0]        thr_q, thr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [MAG_W-1:0]        mag_q, mag_d;
  logic [L-1:0]            idx_q, idx_d;
  logic [RW-1:0]           rank_q, rank_d;

  node_t node_q [NN];
  node_t node_d [NN];
  // ch[k] holds heap node k+1: registered internal nodes first, then the leaves.
  node_t ch [2*N_BINS-2];
  node_t root;
  logic  hit;

  always_comb begin
    ch     = '{default: '0};
    node_d = '{default: '0};
    for (int unsigned n = 1; n < NN; n++) begin
      ch[n-1] = node_q[n];
    end
    for (int unsigned i = 0; i < N_BINS; i++) begin
      ch[NN-1+i].v   = ~mask_q[i];
      ch[NN-1+i].mag = frame_q[i*MAG_W +: MAG_W];
      ch[NN-1+i].idx = L'(i);
    end
    for (int unsigned n = 0; n < NN; n++) begin
      node_d[n] = pick(ch[2*n], ch[2*n+1]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned n = 0; n < NN; n++) begin
        node_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NN; n++) begin
        node_q[n] <= node_d[n];
      end
    end
  end

  assign root = node_q[0];
  assign hit  = root.v && (root.mag > thr_q);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mask_d       = mask_q;
    frame_d      = frame_q;
    thr_d        = thr_q;
    cnt_d        = cnt_q;
    mag_d        = mag_q;
    idx_d        = idx_q;
    rank_d       = rank_q;
    peak_valid_o = 1'b0;
    done_o       = 1'b0;
    peak_count_o = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          frame_d = data_in_i;
          thr_d   = threshold_i;
          mask_d  = '0;
          cnt_d   = '0;
          wait_d  = '0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        // Tree result for the current mask appears after L register levels.
        if (wait_q == L'(L - 1)) begin
          state_d = StEmit;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StEmit: begin
        wait_d = '0;
        if (hit) begin
          peak_valid_o       = 1'b1;
          mag_d              = root.mag;
          idx_d              = root.idx;
          rank_d             = RW'(cnt_q);
          mask_d[root.idx]   = 1'b1;
`ifdef FIND_PEAKS_NEIGHBOR_SUPPRESS_EN
          if (root.idx != '0) begin
            mask_d[root.idx - 1'b1] = 1'b1;
          end
          if (root.idx != L'(N_BINS - 1)) begin
            mask_d[root.idx + 1'b1] = 1'b1;
          end
`endif
          cnt_d        = cnt_q + CW'(1);
          peak_count_o = cnt_d;
          if (cnt_q == CW'(K_PEAKS - 1)) begin
            done_o  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StSearch;
          end
        end else begin
          // Best remaining bin fails, so every later pass would fail too.
          done_o  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Peak fields show the new value during the pulse and hold afterwards.
  assign peak_mag_o  = mag_d;
  assign peak_idx_o  = idx_d;
  assign peak_rank_o = rank_d;
  assign busy_o      = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      wait_q  <= '0;
      mask_q  <= '0;
      frame_q <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
      idx_q   <= '0;
      rank_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      idx_q   <= idx_d;
      rank_q  <= rank_d;
    end
  end

endmodule

// File: tb/tb_find_k_peaks.sv
// Directed bench for find_k_peaks with N_BINS=16, K_PEAKS=3, MAG_W=16, threshold 64.
module tb_find_k_peaks;

  localparam int unsigned NB = 16;
  localparam int unsigned MW = 16;
  localparam int unsigned KP = 3;
  localparam int unsigned LL = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NB*MW-1:0] din = '0;
  logic [MW-1:0]    thr = 16'd64;
  logic             pv;
  logic [MW-1:0]    pmag;
  logic [LL-1:0]    pidx;
  logic [1:0]       prank;
  logic             busy;
  logic             done;
  logic [1:0]       pcnt;

  int total = 0;
  int bad   = 0;

  int npk;
  int pk_cyc  [8];
  int pk_mag  [8];
  int pk_idx  [8];
  int pk_rank [8];
  int done_cyc, done_cnt, busy_ok, busy_after, cnt_after, hold_mag, late_done;
  logic [MW-1:0] exp_hold;

  always #5 clk = ~clk;

  find_k_peaks #(
    .N_BINS (NB),
    .MAG_W  (MW),
    .K_PEAKS(KP)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .start_i     (start),
    .data_in_i   (din),
    .threshold_i (thr),
    .peak_valid_o(pv),
    .peak_mag_o  (pmag),
    .peak_idx_o  (pidx),
    .peak_rank_o (prank),
    .busy_o      (busy),
    .done_o      (done),
    .peak_count_o(pcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB*MW-1:0] mk(input int bg, input int b0, input int m0,
                                           input int b1, input int m1,
                                           input int b2, input int m2);
    logic [NB*MW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*MW +: MW] = MW'(bg);
    if (b0 >= 0) v[b0*MW +: MW] = MW'(m0);
    if (b1 >= 0) v[b1*MW +: MW] = MW'(m1);
    if (b2 >= 0) v[b2*MW +: MW] = MW'(m2);
    return v;
  endfunction

  // Called right after a clock edge: that cycle is cycle 0 with start high.
  task automatic run_frame(input logic [NB*MW-1:0] d, input int late_start,
                           input int zero_cyc, input int rst_cyc);
    npk = 0; done_cyc = -1; done_cnt = -1; busy_ok = 1; hold_mag = -1;
    din = d; thr = 16'd64; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (cyc == 1) start = 1'b0;
      if (pv && npk < 8) begin
        pk_cyc[npk] = cyc; pk_mag[npk] = int'(pmag);
        pk_idx[npk] = int'(pidx); pk_rank[npk] = int'(prank);
        npk++;
      end
      if (cyc == LL + 2) hold_mag = int'(pmag);
      if (!busy) busy_ok = 0;
      if (done) begin
        done_cyc = cyc; done_cnt = int'(pcnt);
        break;
      end
      if (cyc == zero_cyc) din = '0;
      if (cyc == late_start) start = 1'b1;
      if (cyc == late_start + 1) start = 1'b0;
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst mid mag", pmag, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid misc", {pv, done, pidx, prank, pcnt}, 0);
        break;
      end
    end
    if (rst_cyc < 0) begin
      tick();
      busy_after = int'(busy);
      cnt_after  = int'(pcnt);
    end
  endtask

  task automatic exp_pk(input string s, input int r, input int c, input int m, input int i);
    chk($sformatf("%s pk%0d cycle", s, r), pk_cyc[r], c);
    chk($sformatf("%s pk%0d mag", s, r), pk_mag[r], m);
    chk($sformatf("%s pk%0d idx", s, r), pk_idx[r], i);
    chk($sformatf("%s pk%0d rank", s, r), pk_rank[r], r);
  endtask

  task automatic exp_end(input string s, input int np, input int dc, input int cnt);
    chk({s, " npeaks"}, npk, np);
    chk({s, " done cycle"}, done_cyc, dc);
    chk({s, " count"}, done_cnt, cnt);
    chk({s, " busy during"}, busy_ok, 1);
    chk({s, " busy after"}, busy_after, 0);
    chk({s, " count held"}, cnt_after, cnt);
  endtask

  initial begin
    logic [NB*MW-1:0] s1;
    s1 = mk(10, 3, 200, 7, 150, 12, 100);

    // Reset state
    tick();
    tick();
    chk("reset mag", pmag, 0);
    chk("reset busy", busy, 0);
    chk("reset misc", {pv, done, pidx, prank, pcnt}, 0);
    rst_n = 1'b1;
    tick();

    // Three distinct peaks, frame ends on K_PEAKS
    run_frame(s1, -1, -1, -1);
    exp_pk("s1", 0, 5, 200, 3);
    exp_pk("s1", 1, 10, 150, 7);
    exp_pk("s1", 2, 15, 100, 12);
    exp_end("s1", 3, 15, 3);
    chk("s1 mag held", hold_mag, 200);

    // Single qualifying bin, ends early on a failing pass
    run_frame(mk(0, 5, 80, -1, 0, -1, 0), -1, -1, -1);
    exp_pk("s2", 0, 5, 80, 5);
    exp_end("s2", 1, 10, 1);

    // Every bin equals the threshold: nothing qualifies
    run_frame(mk(64, -1, 0, -1, 0, -1, 0), -1, -1, -1);
    exp_end("s2b", 0, 5, 0);

    // Tie: lower index first
    run_frame(mk(0, 2, 300, 9, 300, -1, 0), -1, -1, -1);
    exp_pk("s3", 0, 5, 300, 2);
    exp_pk("s3", 1, 10, 300, 9);
    exp_end("s3", 2, 15, 2);

    // Start while busy and data change after capture have no effect
    run_frame(s1, 3, 1, -1);
    exp_pk("s4", 0, 5, 200, 3);
    exp_pk("s4", 1, 10, 150, 7);
    exp_pk("s4", 2, 15, 100, 12);
    exp_end("s4", 3, 15, 3);
    late_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy || done) late_done = 1;
    end
    chk("s4 no extra frame", late_done, 0);

    // Reset mid-frame, then a clean rerun
    run_frame(s1, -1, -1, 7);
    late_done = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy) late_done = 1;
    end
    chk("s5 no done after abort", late_done, 0);
    run_frame(s1, -1, -1, -1);
    exp_pk("s5", 0, 5, 200, 3);
    exp_pk("s5", 1, 10, 150, 7);
    exp_pk("s5", 2, 15, 100, 12);
    exp_end("s5", 3, 15, 3);

    // Adjacent bins of one lobe
    run_frame(mk(0, 4, 200, 5, 190, 9, 120), -1, -1, -1);
    exp_pk("s6", 0, 5, 200, 4);
`ifdef FIND_PEAKS_NEIGHBOR_SUPPRESS_EN
    exp_pk("s6", 1, 10, 120, 9);
    exp_end("s6", 2, 15, 2);
`else
    exp_pk("s6", 1, 10, 190, 5);
    exp_pk("s6", 2, 15, 120, 9);
    exp_end("s6", 3, 15, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
